// File: rtl/led_column_scanner_pkg.sv
// Shared definitions for the LED column scanner: FSM state encoding and the
// frame bit-layout helper used by every frame producer.
package led_column_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Pixel (col, row) lives at bit col*rows + row of a flattened frame.
    function automatic int pixel_index(input int col, input int row, input int rows);
        return col * rows + row;
    endfunction

endpackage

// File: rtl/led_column_scanner_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load
// of N-1 gives a phase exactly N cycles long.
module scan_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/led_column_scanner.sv
// Time-multiplexed LED column driver with blanking gaps and a double-buffered
// frame that only swaps at a frame boundary (entry into BLANK of column 0).
module led_column_scanner
    import led_column_scanner_pkg::*;
#(
    parameter int COLS  = 8,
    parameter int ROWS  = 8,
    parameter int SEL_W = 3,
    parameter int DWELL = 1000,
    parameter int BLANK = 16,
    parameter int CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [COLS*ROWS-1:0] frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ack,
    output logic                 frame_start,
    output logic [SEL_W-1:0]     select,
    output logic [COLS-1:0]      col_en,
    output logic [ROWS-1:0]      row_q
);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_COL   = SEL_W'(COLS - 1);

    scan_state_t            state_reg, state_next;
    logic [SEL_W-1:0]       select_reg, select_next;
    logic [COLS-1:0]        col_en_reg, col_en_next;
    logic [ROWS-1:0]        row_q_reg, row_q_next;
    logic                   frame_ack_reg, frame_start_reg;
    logic [COLS*ROWS-1:0]   active_reg, active_next;
    logic [COLS*ROWS-1:0]   shadow_reg, shadow_next;
    logic                   pending_reg, pending_next;

    logic                   timer_load;
    logic [CNT_W-1:0]       timer_value;
    logic                   timer_tc;
    logic                   boundary;
    logic                   swap;

    logic [ROWS-1:0]        col_rows [COLS];
    logic [COLS-1:0]        onehot_next;

    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_rows[gi]    = active_reg[pixel_index(gi, 0, ROWS) +: ROWS];
        assign onehot_next[gi] = (select_next == SEL_W'(gi));
    end

    always_comb begin
        state_next  = state_reg;
        select_next = select_reg;
        timer_load  = 1'b0;
        timer_value = BLANK_LOAD;
        boundary    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                select_next = '0;
                if (enable) begin
                    state_next = ST_BLANK;
                    timer_load = 1'b1;
                    boundary   = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_next  = ST_IDLE;
                    select_next = '0;
                end else if (timer_tc) begin
                    state_next  = ST_DRIVE;
                    timer_load  = 1'b1;
                    timer_value = DWELL_LOAD;
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    state_next  = ST_IDLE;
                    select_next = '0;
                end else if (timer_tc) begin
                    state_next = ST_BLANK;
                    timer_load = 1'b1;
                    // Wrap at COLS-1 so unused select codes never appear.
                    if (select_reg == LAST_COL) begin
                        select_next = '0;
                        boundary    = 1'b1;
                    end else begin
                        select_next = select_reg + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_next  = ST_IDLE;
                select_next = '0;
            end
        endcase

        // A write landing on the boundary cycle bypasses the shadow.
        swap         = boundary && (pending_reg || frame_valid);
        active_next  = active_reg;
        if (swap) begin
            active_next = frame_valid ? frame_in : shadow_reg;
        end
        shadow_next  = frame_valid ? frame_in : shadow_reg;
        pending_next = swap ? 1'b0 : (pending_reg || frame_valid);

        col_en_next = '0;
        row_q_next  = '0;
        if (state_next == ST_DRIVE) begin
            col_en_next = onehot_next;
            row_q_next  = col_rows[select_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            select_reg      <= '0;
            col_en_reg      <= '0;
            row_q_reg       <= '0;
            frame_ack_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            active_reg      <= '0;
            shadow_reg      <= '0;
            pending_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            select_reg      <= select_next;
            col_en_reg      <= col_en_next;
            row_q_reg       <= row_q_next;
            frame_ack_reg   <= swap;
            frame_start_reg <= boundary;
            active_reg      <= active_next;
            shadow_reg      <= shadow_next;
            pending_reg     <= pending_next;
        end
    end

    assign select      = select_reg;
    assign col_en      = col_en_reg;
    assign row_q       = row_q_reg;
    assign frame_ack   = frame_ack_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_led_column_scanner.sv
// Randomized and directed bench for led_column_scanner, compared every cycle
// against a position-in-frame arithmetic model of the scan.
module tb_led_column_scanner;

    localparam int COLS   = 8;
    localparam int ROWS   = 8;
    localparam int SEL_W  = 3;
    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int CNT_W  = 4;
    localparam int COLPER = BLANK + DWELL;
    localparam int FRAME  = COLS * COLPER;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [COLS*ROWS-1:0] frame_in = '0;
    logic                 frame_valid = 1'b0;
    logic                 frame_ack;
    logic                 frame_start;
    logic [SEL_W-1:0]     select;
    logic [COLS-1:0]      col_en;
    logic [ROWS-1:0]      row_q;

    int err_count   = 0;
    int check_count = 0;

    // Reference model: scan position within the frame plus buffer contents.
    bit          m_run     = 1'b0;
    int          m_t       = 0;
    logic [63:0] m_active  = '0;
    logic [63:0] m_shadow  = '0;
    bit          m_pending = 1'b0;
    bit          m_ack     = 1'b0;

    led_column_scanner #(
        .COLS(COLS), .ROWS(ROWS), .SEL_W(SEL_W),
        .DWELL(DWELL), .BLANK(BLANK), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_start (frame_start),
        .select      (select),
        .col_en      (col_en),
        .row_q       (row_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit en, input bit fv, input logic [63:0] fin, input bit rst);
        m_ack = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_t = 0;
            m_active = '0; m_shadow = '0; m_pending = 1'b0;
        end else begin
            if (!en) begin
                m_run = 1'b0;
                m_t = 0;
            end else begin
                m_t   = m_run ? (m_t + 1) % FRAME : 0;
                m_run = 1'b1;
                if (m_t == 0 && (m_pending || fv)) begin
                    m_active  = fv ? fin : m_shadow;
                    m_pending = 1'b0;
                    m_ack     = 1'b1;
                end
            end
            if (fv) begin
                m_shadow = fin;
                if (!m_ack) m_pending = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        int          col;
        bit          drive;
        logic [63:0] e_sel, e_col, e_row, e_fs, e_ack;
        e_sel = '0; e_col = '0; e_row = '0; e_fs = '0; e_ack = '0;
        if (m_run) begin
            col   = m_t / COLPER;
            drive = (m_t % COLPER) >= BLANK;
            e_sel = 64'(col);
            e_fs  = 64'(m_t == 0);
            e_ack = 64'(m_ack);
            if (drive) begin
                e_col = 64'(1) << col;
                e_row = (m_active >> (col * ROWS)) & 64'hff;
            end
        end
        check("select", 64'(select), e_sel);
        check("col_en", 64'(col_en), e_col);
        check("row_q", 64'(row_q), e_row);
        check("frame_start", 64'(frame_start), e_fs);
        check("frame_ack", 64'(frame_ack), e_ack);
    endtask

    task automatic step(input bit en, input bit fv, input logic [63:0] fin, input bit rst);
        enable = en; frame_valid = fv; frame_in = fin; reset = rst;
        if (fv) $display("write data=%h t=%0d run=%0d at %0t", fin, m_t, m_run, $time);
        @(posedge clk);
        model_edge(en, fv, fin, rst);
        #1;
        compare_outputs();
        if (frame_ack) $display("ack active=%h at %0t", m_active, $time);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    // Advance with enable high until the model reaches frame position t.
    task automatic run_to(input int t);
        int guard;
        guard = 0;
        while (!(m_run && m_t == t) && guard < 4 * FRAME) begin
            step(1'b1, 1'b0, '0, 1'b0);
            guard++;
        end
        check("run_to_timeout", 64'(guard >= 4 * FRAME), 64'(0));
    endtask

    logic [63:0] diag;

    initial begin
        diag = '0;
        for (int c = 0; c < COLS; c++) diag[c * ROWS + c] = 1'b1;

        $display("phase reset");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);

        $display("phase blank scan");
        run_idle(2 * FRAME + 5);

        $display("phase diagonal");
        run_to(20);
        step(1'b1, 1'b1, diag, 1'b0);
        run_to(0);
        for (int i = 0; i < FRAME; i++) begin
            if (m_t % COLPER >= BLANK)
                check("diag_row", 64'(row_q), 64'(1) << (m_t / COLPER));
            step(1'b1, 1'b0, '0, 1'b0);
        end

        $display("phase double write");
        run_to(10);
        step(1'b1, 1'b1, {8{8'hAA}}, 1'b0);
        run_to(30);
        step(1'b1, 1'b1, {8{8'h55}}, 1'b0);
        run_idle(FRAME + 10);

        $display("phase boundary bypass");
        run_to(FRAME - 1);
        step(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_idle(FRAME);

        $display("phase enable drop");
        run_to(5 * COLPER + BLANK + 1);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
        run_idle(FRAME + 3);

        $display("phase reset while pending");
        run_to(7);
        step(1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b0);
        run_to(3 * COLPER + BLANK);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        run_idle(FRAME + 8);

        $display("phase random");
        for (int i = 0; i < 4000; i++) begin
            bit          en, fv, rst;
            logic [63:0] d;
            en  = ($urandom_range(0, 199) != 0);
            fv  = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 799) == 0);
            d   = {$urandom, $urandom};
            step(en, fv, d, rst);
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
